// File: rtl/maf_cpa_pipe.sv
// rtl/maf_cpa_pipe.sv - two-stage split carry-propagate adder with LZC and zero detect
module maf_cpa_pipe #(
  parameter int WIDTH = 48,
  parameter int SPLIT = 24,
  parameter int LZW   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] carry_in,
  input  logic [WIDTH-1:0] sum_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             cout,
  output logic [LZW-1:0]   lzc,
  output logic             zero
);

  localparam int HW = WIDTH - SPLIT;

  logic          s1_valid;
  logic [SPLIT:0] s1_lo;
  logic [HW-1:0] s1_c_hi;
  logic [HW-1:0] s1_s_hi;
  logic          s2_valid;

  logic          s2_free;
  logic          s1_adv;
  logic          accept;
  logic [SPLIT:0] lo_sum;
  logic [HW:0]   hi_sum;
  logic [WIDTH-1:0] prod_nxt;
  logic [LZW-1:0]   lzc_nxt;

  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !s1_valid || s2_free;
  assign accept    = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign lo_sum   = {1'b0, carry_in[SPLIT-1:0]} + {1'b0, sum_in[SPLIT-1:0]};
  // Low-half carry c1 enters the upper adder as its carry-in.
  assign hi_sum   = {1'b0, s1_c_hi} + {1'b0, s1_s_hi} + {{HW{1'b0}}, s1_lo[SPLIT]};
  assign prod_nxt = {hi_sum[HW-1:0], s1_lo[SPLIT-1:0]};

  always_comb begin
    lzc_nxt = LZW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (prod_nxt[i]) lzc_nxt = LZW'(WIDTH - 1 - i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c_hi  <= '0;
      s1_s_hi  <= '0;
      s2_valid <= 1'b0;
      product  <= '0;
      cout     <= 1'b0;
      lzc      <= '0;
      zero     <= 1'b0;
    end else begin
      if (accept) begin
        s1_lo    <= lo_sum;
        s1_c_hi  <= carry_in[WIDTH-1:SPLIT];
        s1_s_hi  <= sum_in[WIDTH-1:SPLIT];
        s1_valid <= 1'b1;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end

      if (s1_adv) begin
        product  <= prod_nxt;
        cout     <= hi_sum[HW];
        lzc      <= lzc_nxt;
        zero     <= (prod_nxt == '0);
        s2_valid <= 1'b1;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_maf_cpa_pipe.sv
// tb/tb_maf_cpa_pipe.sv - directed self-checking bench for maf_cpa_pipe
module tb_maf_cpa_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] carry_in;
  logic [47:0] sum_in;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        cout;
  logic [5:0]  lzc;
  logic        zero;

  int total = 0;
  int bad   = 0;

  maf_cpa_pipe #(.WIDTH(48), .SPLIT(24), .LZW(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .carry_in(carry_in), .sum_in(sum_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .cout(cout), .lzc(lzc), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [47:0] va [0:7];
  logic [47:0] vb [0:7];

  function automatic logic [48:0] ref_sum(input logic [47:0] a, input logic [47:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [5:0] ref_lzc(input logic [47:0] p);
    for (int i = 47; i >= 0; i--) begin
      if (p[i]) return 6'(47 - i);
    end
    return 6'd48;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    carry_in = 'x; sum_in = 'x;
    cyc(); cyc();
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    total++; if (product !== 48'h0) begin bad++; $display("FAIL reset_product got=%h exp=0", product); end
    total++; if ({cout, zero, lzc} !== 8'h00) begin bad++; $display("FAIL reset_flags got cout=%0b zero=%0b lzc=%0d exp all 0", cout, zero, lzc); end
  endtask

  task automatic test_vector(input string name, input logic [47:0] a, input logic [47:0] b,
                             input logic [47:0] ep, input logic ec, input logic [5:0] el, input logic ez);
    out_ready = 1'b1;
    in_valid = 1'b1; carry_in = a; sum_in = b;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready got=%0b exp=1", name, in_ready); end
    cyc();
    in_valid = 1'b0; carry_in = 'x; sum_in = 'x;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid got=%0b exp=0", name, out_valid); end
    cyc();
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency got=%0b exp=1", name, out_valid); end
    total++; if (product !== ep) begin bad++; $display("FAIL %s_product got=%h exp=%h", name, product, ep); end
    total++; if (cout !== ec) begin bad++; $display("FAIL %s_cout got=%0b exp=%0b", name, cout, ec); end
    total++; if (lzc !== el) begin bad++; $display("FAIL %s_lzc got=%0d exp=%0d", name, lzc, el); end
    total++; if (zero !== ez) begin bad++; $display("FAIL %s_zero got=%0b exp=%0b", name, zero, ez); end
    cyc();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s_drain got=%0b exp=0", name, out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [48:0] s;
    out_ready = 1'b1;
    for (int c = 0; c < 11; c++) begin
      if (c >= 2 && c < 10) begin
        s = ref_sum(va[c-2], vb[c-2]);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%0b exp=1", c-2, out_valid); end
        total++; if ({cout, product} !== s) begin bad++; $display("FAIL b2b_data[%0d] got=%0b_%h exp=%0b_%h", c-2, cout, product, s[48], s[47:0]); end
        total++; if (lzc !== ref_lzc(s[47:0]) || zero !== (s[47:0] == 48'h0)) begin
          bad++; $display("FAIL b2b_lzc[%0d] got lzc=%0d zero=%0b exp lzc=%0d", c-2, lzc, zero, ref_lzc(s[47:0]));
        end
      end else if (c == 10) begin
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%0b exp=0", out_valid); end
      end
      if (c < 8) begin
        in_valid = 1'b1; carry_in = va[c]; sum_in = vb[c];
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", c, in_ready); end
      end else begin
        in_valid = 1'b0; carry_in = 'x; sum_in = 'x;
      end
      cyc();
    end
  endtask

  task automatic test_stall();
    logic [48:0] s;
    int idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; carry_in = va[idx]; sum_in = vb[idx];
      #1;
      total++; if (in_ready !== (c < 2)) begin bad++; $display("FAIL stall_in_ready[%0d] got=%0b exp=%0b", c, in_ready, c < 2); end
      if (c >= 2) begin
        s = ref_sum(va[0], vb[0]);
        total++; if (out_valid !== 1'b1 || {cout, product} !== s) begin
          bad++; $display("FAIL stall_hold[%0d] got v=%0b %h exp v=1 %h", c, out_valid, product, s[47:0]);
        end
      end
      cyc();
      if (c < 2) idx++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    for (int k = 0; k < 3; k++) begin
      s = ref_sum(va[k], vb[k]);
      total++; if (out_valid !== 1'b1 || {cout, product} !== s) begin
        bad++; $display("FAIL release_order[%0d] got v=%0b %h exp v=1 %h", k, out_valid, product, s[47:0]);
      end
      cyc();
      in_valid = 1'b0; carry_in = 'x; sum_in = 'x;
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL release_dup got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_flush();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in_valid = 1'b1; carry_in = va[c + 3]; sum_in = vb[c + 3];
      cyc();
    end
    in_valid = 1'b0; carry_in = 'x; sum_in = 'x;
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL flush_full got rdy=%0b v=%0b exp rdy=0 v=1", in_ready, out_valid);
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush_ctrl got v=%0b rdy=%0b exp v=0 rdy=1", out_valid, in_ready);
    end
    total++; if ({product, cout, lzc, zero} !== 56'h0) begin
      bad++; $display("FAIL flush_data got p=%h c=%0b l=%0d z=%0b exp 0", product, cout, lzc, zero);
    end
    for (int c = 0; c < 4; c++) begin
      cyc();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_stale[%0d] got=%0b exp=0", c, out_valid); end
    end
  endtask

  initial begin
    va[0] = 48'h123456_789ABC; vb[0] = 48'h0FEDCB_A98765;
    va[1] = 48'hFFFFFF_000000; vb[1] = 48'h000001_000000;
    va[2] = 48'h000000_FFFFFF; vb[2] = 48'h000000_000001;
    va[3] = 48'h800000_000000; vb[3] = 48'h7FFFFF_FFFFFF;
    va[4] = 48'h000000_000000; vb[4] = 48'h000000_000000;
    va[5] = 48'hA5A5A5_5A5A5A; vb[5] = 48'h5A5A5A_A5A5A6;
    va[6] = 48'h000000_000003; vb[6] = 48'h000000_000004;
    va[7] = 48'hDEADBE_EFCAFE; vb[7] = 48'hC0FFEE_123456;

    test_reset();
    test_vector("wrap_zero", 48'h000000000001, 48'hFFFFFFFFFFFF, 48'h0, 1'b1, 6'd48, 1'b1);
    test_vector("split_carry", 48'h000000000001, 48'h000000FFFFFF, 48'h000001000000, 1'b0, 6'd23, 1'b0);
    test_vector("all_ones", 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFF, 48'hFFFFFFFFFFFE, 1'b1, 6'd0, 1'b0);
    test_back_to_back();
    test_stall();
    test_reset_flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
